// File: rtl/boot_loader_ctrl.sv
// Boot loader: assembles a byte stream into little-endian words, writes them to instruction memory,
// then releases the core. Define BOOT_LOADER_CHECKSUM_EN to add the trailing 32-bit checksum compare.
module boot_loader_ctrl #(
  parameter int IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        start,
  input  logic [10:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [9:0]  im_waddr,
  output logic [31:0] im_wdata,
  output logic        core_resetb,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERROR} state_t;

  state_t      state_q, state_d;
  logic [10:0] words_left_q;
  logic [1:0]  lane_q;
  logic [23:0] asm_q;
  logic        im_we_q;
  logic [9:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        core_resetb_q;

  logic [10:0] eff_count;
  logic        start_ok;
  logic        byte_acc;
  logic        last_byte;
  logic        last_write;

  assign eff_count  = (word_count > 11'(IM_WORDS)) ? 11'(IM_WORDS) : word_count;
  assign start_ok   = start && (state_q inside {S_IDLE, S_RUN, S_ERROR});
  assign byte_acc   = byte_valid && byte_ready;
  assign last_byte  = byte_acc && (lane_q == 2'd3);
  assign last_write = im_we_q && (words_left_q == 11'd1);

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        sum_match;

  assign sum_match = ({byte_data, asm_q} == sum_q);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (im_we_q) begin
      sum_q <= sum_q + wdata_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start_ok) begin
          if (eff_count != 11'd0) state_d = S_LOAD;
`ifdef BOOT_LOADER_CHECKSUM_EN
          else                    state_d = S_CHECK;
`else
          else                    state_d = S_RUN;
`endif
        end
      end
      S_LOAD: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (last_write) state_d = S_CHECK;
`else
        if (last_write) state_d = S_RUN;
`endif
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (last_byte) state_d = sum_match ? S_RUN : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    error      = 1'b0;
    case (state_q)
      S_LOAD, S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_ERROR: error = 1'b1;
`endif
      default: ;
    endcase
  end

  // The byte after a word's final byte may arrive during the write cycle, so the lane keeps counting.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      words_left_q  <= '0;
      lane_q        <= '0;
      asm_q         <= '0;
      im_we_q       <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      core_resetb_q <= 1'b0;
    end else begin
      im_we_q       <= (state_q == S_LOAD) && last_byte;
      core_resetb_q <= (state_d == S_RUN);
      if (start_ok) begin
        words_left_q <= eff_count;
        lane_q       <= 2'd0;
        waddr_q      <= '0;
      end else begin
        if (byte_acc) lane_q <= lane_q + 2'd1;
        if (im_we_q) begin
          words_left_q <= words_left_q - 11'd1;
          if (!last_write) waddr_q <= waddr_q + 10'd1;
        end
      end
      if (byte_acc) begin
        case (lane_q)
          2'd0:    asm_q[7:0]   <= byte_data;
          2'd1:    asm_q[15:8]  <= byte_data;
          2'd2:    asm_q[23:16] <= byte_data;
          default: ;
        endcase
      end
      if ((state_q == S_LOAD) && last_byte) wdata_q <= {byte_data, asm_q};
    end
  end

  assign im_we       = im_we_q;
  assign im_waddr    = waddr_q;
  assign im_wdata    = wdata_q;
  assign core_resetb = core_resetb_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: directed and randomized loads compared against a
// word-list/checksum model derived from the byte stream.
module tb_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        start = 1'b0;
  logic [10:0] word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        im_we;
  logic [9:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        core_resetb;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boot_loader_ctrl #(.IM_WORDS(1024)) dut (
    .clk         (clk),
    .resetb      (resetb),
    .start       (start),
    .word_count  (word_count),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .im_we       (im_we),
    .im_waddr    (im_waddr),
    .im_wdata    (im_wdata),
    .core_resetb (core_resetb),
    .busy        (busy),
    .error       (error)
  );

  logic [41:0] wq[$];
  int          cyc = 0;
  int          we_cyc = -1;
  int          rise_cyc = -1;
  logic        prev_cr = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (im_we === 1'b1) begin
      wq.push_back({im_waddr, im_wdata});
      we_cyc = cyc;
    end
    if (core_resetb === 1'b1 && prev_cr !== 1'b1) rise_cyc = cyc;
    prev_cr = core_resetb;
  end

  logic [7:0]  tx_q[$];
  logic [41:0] exp_q[$];
  logic [31:0] exp_sum;

  task automatic make_bytes(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  // Reference: word w is bytes 4w..4w+3, LSB first, stored at address w; only min(wc,1024) words.
  task automatic build_model(input int wc);
    int eff;
    eff = (wc > 1024) ? 1024 : wc;
    exp_q.delete();
    exp_sum = '0;
    for (int w = 0; w < eff; w++) begin
      logic [31:0] d;
      d = {tx_q[4*w+3], tx_q[4*w+2], tx_q[4*w+1], tx_q[4*w]};
      exp_q.push_back({w[9:0], d});
      exp_sum = exp_sum + d;
    end
  endtask

  task automatic add_trailer(input logic [31:0] v);
    tx_q.push_back(v[7:0]);
    tx_q.push_back(v[15:8]);
    tx_q.push_back(v[23:16]);
    tx_q.push_back(v[31:24]);
  endtask

  task automatic clear_obs();
    wq.delete();
    we_cyc = -1;
    rise_cyc = -1;
  endtask

  task automatic do_start(input int wc);
    @(posedge clk); #1;
    start = 1'b1;
    word_count = 11'(wc);
    @(posedge clk); #1;
    start = 1'b0;
    word_count = 11'($urandom);
  endtask

  // mode 0: continuous, 1: valid toggles 1/0, 2: random idle gaps
  task automatic feed(input int mode, input int first, input int last, output bit ok);
    bit acc;
    int guard;
    ok = 1'b1;
    acc = 1'b0;
    for (int i = first; i <= last; i++) begin
      int idle;
      idle = (mode == 1) ? ((i > first) ? 1 : 0) : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (idle) begin
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
        @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_data = tx_q[i];
      guard = 0;
      do begin
        @(negedge clk);
        acc = byte_ready;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) begin
        ok = 1'b0;
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (core_resetb !== 1'b0) begin errors++; $display("FAIL reset_core_resetb got %b exp 0", core_resetb); end
    checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL reset_im_we got %b exp 0", im_we); end
    checks++; if (im_waddr !== 10'd0) begin errors++; $display("FAIL reset_im_waddr got %0d exp 0", im_waddr); end
    checks++; if (im_wdata !== 32'd0) begin errors++; $display("FAIL reset_im_wdata got %h exp 0", im_wdata); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got %b exp 0", byte_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    @(posedge clk); #1;
    resetb = 1'b1;
    byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || core_resetb !== 1'b0 || im_we !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy %b core_resetb %b im_we %b exp 0 0 0", busy, core_resetb, im_we);
    end
  endtask

  task automatic test_basic(input int mode);
    bit ok_f, ok_d;
    tx_q.delete();
    tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    build_model(2);
    checks++; if (exp_q[0][31:0] !== 32'h13 || exp_q[1][31:0] !== 32'h6F) begin
      errors++; $display("FAIL basic_model got %h %h exp 00000013 0000006f", exp_q[0][31:0], exp_q[1][31:0]);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    add_trailer(exp_sum);
`endif
    clear_obs();
    do_start(2);
    feed(mode, 0, tx_q.size() - 1, ok_f);
    wait_done(100, ok_d);
    checks++; if (!ok_f || !ok_d) begin errors++; $display("FAIL basic_timeout mode %0d feed %b done %b exp 1 1", mode, ok_f, ok_d); end
    checks++; if (wq.size() != exp_q.size()) begin errors++; $display("FAIL basic_count mode %0d got %0d exp %0d", mode, wq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++; if (wq[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_write[%0d] mode %0d got @%0d %h exp @%0d %h", i, mode, wq[i][41:32], wq[i][31:0], exp_q[i][41:32], exp_q[i][31:0]);
      end
    end
    checks++; if (core_resetb !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL basic_run mode %0d got core_resetb %b error %b exp 1 0", mode, core_resetb, error); end
`ifndef BOOT_LOADER_CHECKSUM_EN
    checks++; if (rise_cyc != we_cyc + 1) begin errors++; $display("FAIL basic_release mode %0d got rise %0d exp %0d", mode, rise_cyc, we_cyc + 1); end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int wc, mode;
      bit ok_f, ok_d, exp_run;
      wc = int'($urandom_range(0, 6));
      mode = int'($urandom_range(0, 2));
      make_bytes(4 * wc);
      build_model(wc);
      exp_run = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
      exp_run = ($urandom_range(0, 3) != 0);
      add_trailer(exp_run ? exp_sum : (exp_sum ^ (32'h1 << $urandom_range(0, 31))));
`endif
      clear_obs();
      do_start(wc);
      feed(mode, 0, tx_q.size() - 1, ok_f);
      wait_done(200, ok_d);
      checks++; if (!ok_f || !ok_d) begin errors++; $display("FAIL rand_timeout it %0d feed %b done %b exp 1 1", it, ok_f, ok_d); end
      checks++; if (wq.size() != exp_q.size()) begin errors++; $display("FAIL rand_count it %0d got %0d exp %0d", it, wq.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
        checks++; if (wq[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_write[%0d] it %0d got @%0d %h exp @%0d %h", i, it, wq[i][41:32], wq[i][31:0], exp_q[i][41:32], exp_q[i][31:0]);
        end
      end
      checks++; if (core_resetb !== exp_run || error !== !exp_run) begin
        errors++; $display("FAIL rand_final it %0d got core_resetb %b error %b exp %b %b", it, core_resetb, error, exp_run, !exp_run);
      end
`ifndef BOOT_LOADER_CHECKSUM_EN
      if (wc > 0) begin
        checks++; if (rise_cyc != we_cyc + 1) begin errors++; $display("FAIL rand_release it %0d got %0d exp %0d", it, rise_cyc, we_cyc + 1); end
      end
`endif
    end
  endtask

  task automatic test_max();
    bit ok_f, ok_d;
    make_bytes(4096);
    build_model(2047);
`ifdef BOOT_LOADER_CHECKSUM_EN
    add_trailer(exp_sum);
`endif
    clear_obs();
    do_start(2047);
    feed(0, 0, tx_q.size() - 1, ok_f);
    wait_done(100, ok_d);
    checks++; if (!ok_f || !ok_d) begin errors++; $display("FAIL max_timeout feed %b done %b exp 1 1", ok_f, ok_d); end
    checks++; if (wq.size() != 1024) begin errors++; $display("FAIL max_count got %0d exp 1024", wq.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++; if (wq[i] !== exp_q[i]) begin
        errors++; $display("FAIL max_write[%0d] got @%0d %h exp @%0d %h", i, wq[i][41:32], wq[i][31:0], exp_q[i][41:32], exp_q[i][31:0]);
      end
    end
    checks++; if (core_resetb !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL max_run got core_resetb %b busy %b exp 1 0", core_resetb, busy); end
  endtask

  task automatic test_reset_mid_load();
    bit ok_f;
    int n_before;
    make_bytes(12);
    clear_obs();
    do_start(3);
    feed(0, 0, 5, ok_f);
    n_before = wq.size();
    checks++; if (!ok_f || n_before != 1) begin errors++; $display("FAIL midrst_pre got feed %b writes %0d exp 1 1", ok_f, n_before); end
    #2;
    resetb = 1'b0;
    #1;
    checks++; if (im_we !== 1'b0 || im_waddr !== 10'd0 || im_wdata !== 32'd0) begin
      errors++; $display("FAIL midrst_mem got we %b addr %0d data %h exp 0 0 0", im_we, im_waddr, im_wdata);
    end
    checks++; if (byte_ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || core_resetb !== 1'b0) begin
      errors++; $display("FAIL midrst_ctl got ready %b busy %b error %b core_resetb %b exp 0 0 0 0", byte_ready, busy, error, core_resetb);
    end
    @(posedge clk); #1;
    resetb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1;
      byte_data = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wq.size() != n_before) begin errors++; $display("FAIL midrst_nowrite got %0d exp %0d", wq.size(), n_before); end
    checks++; if (busy !== 1'b0 || byte_ready !== 1'b0 || core_resetb !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got busy %b ready %b core_resetb %b exp 0 0 0", busy, byte_ready, core_resetb);
    end
  endtask

  task automatic test_restart_from_run();
    bit ok_f, ok_d;
    make_bytes(8);
    build_model(2);
`ifdef BOOT_LOADER_CHECKSUM_EN
    add_trailer(exp_sum);
`endif
    do_start(2);
    feed(2, 0, tx_q.size() - 1, ok_f);
    wait_done(100, ok_d);
    checks++; if (core_resetb !== 1'b1) begin errors++; $display("FAIL restart_pre got core_resetb %b exp 1", core_resetb); end
    make_bytes(4);
    build_model(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
    add_trailer(exp_sum);
`endif
    clear_obs();
    do_start(1);
    checks++; if (core_resetb !== 1'b0) begin errors++; $display("FAIL restart_reload got core_resetb %b exp 0", core_resetb); end
    feed(0, 0, tx_q.size() - 1, ok_f);
    wait_done(100, ok_d);
    checks++; if (!ok_f || !ok_d || wq.size() != 1) begin errors++; $display("FAIL restart_count got feed %b done %b writes %0d exp 1 1 1", ok_f, ok_d, wq.size()); end
    if (wq.size() > 0) begin
      checks++; if (wq[0] !== exp_q[0]) begin errors++; $display("FAIL restart_write got @%0d %h exp @0 %h", wq[0][41:32], wq[0][31:0], exp_q[0][31:0]); end
    end
    checks++; if (core_resetb !== 1'b1) begin errors++; $display("FAIL restart_run got core_resetb %b exp 1", core_resetb); end
  endtask

  task automatic test_start_ignored();
    bit ok_f, ok_d, rdy;
    make_bytes(8);
    build_model(2);
    clear_obs();
    do_start(2);
    feed(0, 0, 5, ok_f);
    start = 1'b1;
    word_count = 11'd5;
    @(posedge clk); #1;
    start = 1'b0;
    feed(0, 6, 6, ok_f);
    byte_valid = 1'b1;
    byte_data = tx_q[7];
    start = 1'b1;
    word_count = 11'd5;
    @(negedge clk);
    rdy = byte_ready;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    start = 1'b0;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ignore_last_ready got %b exp 1", rdy); end
`ifdef BOOT_LOADER_CHECKSUM_EN
    add_trailer(exp_sum);
    feed(0, 8, 11, ok_f);
`endif
    wait_done(100, ok_d);
    checks++; if (!ok_f || !ok_d || wq.size() != 2) begin errors++; $display("FAIL ignore_count got feed %b done %b writes %0d exp 1 1 2", ok_f, ok_d, wq.size()); end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++; if (wq[i] !== exp_q[i]) begin
        errors++; $display("FAIL ignore_write[%0d] got @%0d %h exp @%0d %h", i, wq[i][41:32], wq[i][31:0], exp_q[i][41:32], exp_q[i][31:0]);
      end
    end
    repeat (4) @(negedge clk);
    checks++; if (core_resetb !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ignore_run got core_resetb %b busy %b exp 1 0", core_resetb, busy); end
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok_f, ok_d;
    tx_q.delete();
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    do_start(2);
    feed(0, 0, tx_q.size() - 1, ok_f);
    wait_done(100, ok_d);
    checks++; if (core_resetb !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL csum_good got core_resetb %b error %b exp 1 0", core_resetb, error); end
    tx_q[8] = 8'h04;
    do_start(2);
    feed(0, 0, tx_q.size() - 1, ok_f);
    wait_done(100, ok_d);
    checks++; if (core_resetb !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL csum_bad got core_resetb %b error %b exp 0 1", core_resetb, error); end
    repeat (3) @(negedge clk);
    checks++; if (core_resetb !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL csum_hold got core_resetb %b error %b exp 0 1", core_resetb, error); end
    tx_q.delete();
    add_trailer(32'h0);
    do_start(0);
    feed(0, 0, 3, ok_f);
    wait_done(100, ok_d);
    checks++; if (!ok_f || !ok_d || core_resetb !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL csum_zero got feed %b done %b core_resetb %b error %b exp 1 1 1 0", ok_f, ok_d, core_resetb, error);
    end
  endtask
`endif

  initial begin
    #800000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_random();
    test_max();
    test_reset_mid_load();
    test_restart_from_run();
    test_start_ignored();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
